// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a registered carry, LSB first,
// with a start/busy/done handshake. The one-bit cell is defined here so the file stands alone.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a_i   (sa_q[0]),
        .b_i   (sb_q[0]),
        .cin_i (c_q),
        .s_o   (fa_s),
        .cout_o(fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
    always_comb begin
        sr_d            = sr_q >> 1;
        sr_d[WIDTH-1]   = fa_s;
    end

    assign last_bit = (cnt_q == LastCnt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= StRun;
                        sa_q    <= a_i;
                        sb_q    <= b_i;
                        c_q     <= cin_i;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    c_q   <= fa_cout;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        state_q <= StDone;
                        sum_q   <= sr_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected sums queued at start acceptance,
// checked when done pulses; also checks handshake timing and reset abort.

module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [WIDTH:0] sb_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .a_i    (a),
        .b_i    (b),
        .cin_i  (cin),
        .busy_o (busy),
        .done_o (done),
        .sum_o  (sum),
        .cout_o (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        logic [WIDTH:0] exp_v;
        if (!rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_v = sb_q.pop_front();
                check_eq("sum", 32'(sum), 32'(exp_v[WIDTH-1:0]));
                check_eq("cout", 32'(cout), 32'(exp_v[WIDTH]));
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        sb_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done is seen (inclusive).
    task automatic wait_done(output int lat, output int busy_n);
        bit got = 0;
        lat    = 0;
        busy_n = 0;
        while (!got && lat < 4 * WIDTH + 8) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
            else if (busy) busy_n++;
        end
        if (!got) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic cv);
        int lat;
        int busy_n;
        logic [WIDTH:0] e;
        e = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        issue(av, bv, cv);
        wait_done(lat, busy_n);
        check_eq("latency", 32'(lat), 32'(WIDTH + 1));
        check_eq("busy_cycles", 32'(busy_n), 32'(WIDTH));
        @(negedge clk);
        check_eq("done_width", 32'(done), 32'd0);
        check_eq("sum_hold", 32'(sum), 32'(e[WIDTH-1:0]));
        check_eq("cout_hold", 32'(cout), 32'(e[WIDTH]));
    endtask

    initial begin
        int d0;
        int gap;
        int lat;
        int busy_n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #3;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_add(8'h00, 8'h00, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0);
        run_add(8'hA5, 8'h5A, 1'b1);
        run_add(8'h3C, 8'h0F, 1'b0);

        // Start during RUN must be ignored: one done, result 0x30.
        d0 = done_cnt;
        issue(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (WIDTH + 6) @(negedge clk);
        check_eq("ignored_start_dones", 32'(done_cnt - d0), 32'd1);

        // Back-to-back: start in the done cycle.
        issue(8'h44, 8'h22, 1'b0);
        wait_done(lat, busy_n);
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        sb_q.push_back(9'h002);
        #1 start = 1'b0;
        check_eq("b2b_busy", 32'(busy), 32'd1);
        gap = 0;
        wait_done(gap, busy_n);
        check_eq("b2b_gap", 32'(gap), 32'(WIDTH + 1));

        // Reset abort mid-RUN.
        issue(8'h77, 8'h11, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_sum", 32'(sum), 32'd0);
        check_eq("abort_cout", 32'(cout), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0  = done_cnt;
        repeat (WIDTH + 4) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_add(8'h80, 8'h80, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_add(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
        end

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
